// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester identifiers and default bus widths.
package dmem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_INT = 1'b0,
        REQ_FP  = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins; on a conflict the
// side that was not served last wins.
module dmem_port_arbiter_rr_pick2
    import dmem_port_arbiter_pkg::*;
(
    input  logic    req_int,
    input  logic    req_fp,
    input  req_id_e rr_last,
    output logic    valid,
    output req_id_e pick
);

    // Select the winner from the current requests and the last-served side.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        valid = req_int | req_fp;
        pick  = REQ_INT;
        if (req_int && req_fp) begin
            pick = (rr_last == REQ_INT) ? REQ_FP : REQ_INT;
        end else if (req_fp) begin
            pick = REQ_FP;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the integer and FP MEM stages.
// Each access runs IDLE -> REQ -> RESP -> ACK; a timeout forces ACK with zero
// data and raises a sticky bus error.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              req_f,
    input  logic              we_f,
    input  logic [ADDR_W-1:0] addr_f,
    input  logic [DATA_W-1:0] wdata_f,
    output logic              ack_i,
    output logic              ack_f,
    output logic [DATA_W-1:0] rdata,
    output logic              stall_i,
    output logic              stall_f,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    req_id_e           winner_q, rr_last_q, pick_id;
    logic              pick_valid;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              latch_en, cap_en, tmo, cnt_clr, cnt_inc;

    dmem_port_arbiter_rr_pick2 u_pick (
        .req_int (req_i),
        .req_fp  (req_f),
        .rr_last (rr_last_q),
        .valid   (pick_valid),
        .pick    (pick_id)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        cap_en   = 1'b0;
        tmo      = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        mem_req  = 1'b0;
        ack_i    = 1'b0;
        ack_f    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    latch_en = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_inc = 1'b1;
                    if (mem_gnt) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    cap_en  = 1'b1;
                    state_d = ST_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_ACK: begin
                ack_i   = (winner_q == REQ_INT);
                ack_f   = (winner_q == REQ_FP);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latched command, response data, timeout counter and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            winner_q  <= REQ_INT;
            rr_last_q <= REQ_FP;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (latch_en) begin
                winner_q <= pick_id;
                we_q     <= (pick_id == REQ_FP) ? we_f    : we_i;
                addr_q   <= (pick_id == REQ_FP) ? addr_f  : addr_i;
                wdata_q  <= (pick_id == REQ_FP) ? wdata_f : wdata_i;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cap_en) rdata_q <= mem_rdata;
            if (tmo) begin
                rdata_q   <= '0;
                bus_err_q <= 1'b1;
            end
            if (state_q == ST_ACK) rr_last_q <= winner_q;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign stall_i   = req_i & ~ack_i;
    assign stall_f   = req_f & ~ack_f;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a transaction-level model of the
// arbiter is compared against the DUT every cycle, with directed scenarios
// pinning literal latencies and a randomized soak at the end.
module tb_dmem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_i = 1'b0, we_i = 1'b0, req_f = 1'b0, we_f = 1'b0;
    logic [AW-1:0] addr_i = '0, addr_f = '0;
    logic [DW-1:0] wdata_i = '0, wdata_f = '0;
    logic          ack_i, ack_f, stall_i, stall_f, mem_req, mem_we, bus_err;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .req_f      (req_f),
        .we_f       (we_f),
        .addr_f     (addr_f),
        .wdata_f    (wdata_f),
        .ack_i      (ack_i),
        .ack_f      (ack_f),
        .rdata      (rdata),
        .stall_i    (stall_i),
        .stall_f    (stall_f),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .bus_err    (bus_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One transaction is in flight at a time: it is chosen in an idle cycle,
    // waits for the memory to accept it, waits for completion (or runs out of
    // TMO cycles), and is acknowledged for a single cycle.
    bit          m_busy = 0;   // a transaction is in flight
    bit          m_gnt  = 0;   // memory has accepted its command
    bit          m_fin  = 0;   // this cycle is its acknowledge cycle
    bit          m_win  = 0;   // 0 = integer side, 1 = FP side
    bit          m_rr   = 1;   // side served last (FP after reset)
    bit          m_berr = 0;
    bit          m_in_rst = 0;
    int          m_el   = 0;   // cycles spent waiting on memory so far
    int          m_rsp  = 0;   // cycles spent waiting for completion so far
    logic        m_we   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0, m_data = '0;
    int          cyc = 0;

    function automatic bit pick_side(bit ri, bit rf, bit rr);
        return (ri && rf) ? !rr : rf;
    endfunction

    // Advance the model by one clock using the inputs sampled at the edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m_in_rst <= !rst;
        if (!rst) begin
            m_busy <= 0; m_gnt <= 0; m_fin <= 0; m_rr <= 1; m_berr <= 0;
            m_el <= 0; m_rsp <= 0;
        end else if (m_fin) begin
            m_rr   <= m_win;
            m_busy <= 0;
            m_fin  <= 0;
        end else if (!m_busy) begin
            if (req_i || req_f) begin
                m_win   <= pick_side(req_i, req_f, m_rr);
                m_we    <= pick_side(req_i, req_f, m_rr) ? we_f    : we_i;
                m_addr  <= pick_side(req_i, req_f, m_rr) ? addr_f  : addr_i;
                m_wdata <= pick_side(req_i, req_f, m_rr) ? wdata_f : wdata_i;
                m_busy  <= 1; m_gnt <= 0; m_el <= 0; m_rsp <= 0;
            end
        end else begin
            if (m_gnt && mem_rvalid) begin
                m_fin <= 1; m_data <= mem_rdata;
            end else if (m_el == TMO - 1) begin
                m_fin <= 1; m_data <= '0; m_berr <= 1;
            end else if (m_gnt) begin
                m_rsp <= m_rsp + 1;
            end else if (mem_gnt) begin
                m_gnt <= 1;
            end
            m_el <= m_el + 1;
        end
    end

    // Compare every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        bit e_ai, e_af, e_mreq;
        if (cyc > 0) begin
            e_ai   = m_fin && !m_win;
            e_af   = m_fin && m_win;
            e_mreq = m_busy && !m_gnt && !m_fin;
            check("ack_i", ack_i, e_ai);
            check("ack_f", ack_f, e_af);
            check("stall_i", stall_i, req_i & ~e_ai);
            check("stall_f", stall_f, req_f & ~e_af);
            check("mem_req", mem_req, e_mreq);
            check("bus_err", bus_err, m_berr);
            if (e_mreq) begin
                check("mem_we", mem_we, m_we);
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_fin) check("rdata", rdata, m_data);
            if (m_in_rst) begin
                check("rst_rdata", rdata, 0);
                check("rst_mem_we", mem_we, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
            end
        end
    end

    // ---------------- memory responder / stimulus helpers ----------------
    bit          rnd_mem  = 0;
    bit          never_rv = 0;
    int          gnt_wait = 0;
    int          rsp_wait = 0;
    logic [DW-1:0] rd_val = '0;

    // Move to the next cycle and drive the memory side for it.
    task automatic step();
        @(posedge clk);
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = rnd_mem ? DW'($urandom) : rd_val;
        if (m_busy && !m_fin && !m_gnt) begin
            mem_gnt = rnd_mem ? ($urandom_range(0, 2) == 0) : (m_el >= gnt_wait);
            if (rnd_mem) mem_rvalid = ($urandom_range(0, 3) == 0);
        end else if (m_busy && !m_fin && m_gnt) begin
            mem_rvalid = !never_rv && (rnd_mem ? ($urandom_range(0, 2) == 0) : (m_rsp >= rsp_wait));
        end else if (!m_busy && rnd_mem) begin
            mem_rvalid = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req_i = 1'b0; req_f = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Let both requesters finish what they hold, dropping req on their ack.
    task automatic drain();
        bit ai, af;
        for (int k = 0; k < 60 && (req_i || req_f); k++) begin
            @(negedge clk);
            ai = ack_i; af = ack_f;
            step();
            if (ai) req_i = 1'b0;
            if (af) req_f = 1'b0;
        end
        check("drain_done", {req_i, req_f}, 0);
        step();
        step();
    endtask

    logic [AW-1:0] exp_seq [6];

    initial begin
        bit ai, af, prev;
        int ni, nf, seen;

        // ---- integer-only load, minimum latency ----
        do_reset();
        rd_val = 32'hDEAD_BEEF;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("t1_ack_i", ack_i, k == 3);
            check("t1_stall_i", stall_i, k < 3);
            check("t1_ack_f", ack_f, 0);
            if (k == 3) check("t1_rdata", rdata, 32'hDEAD_BEEF);
            step();
            if (k == 3) req_i = 1'b0;
        end

        // ---- simultaneous int store / FP load after reset ----
        do_reset();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h1;
        req_f = 1'b1; we_f = 1'b0; addr_f = 32'h20; wdata_f = 32'h0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check("t2_ack_i", ack_i, k == 3);
            check("t2_ack_f", ack_f, k == 7);
            check("t2_stall_f", stall_f, k < 7);
            if (k == 1) begin
                check("t2_first_addr", mem_addr, 32'h10);
                check("t2_first_we", mem_we, 1);
                check("t2_first_wdata", mem_wdata, 32'h1);
            end
            if (k == 5) check("t2_second_addr", mem_addr, 32'h20);
            step();
            if (k == 3) req_i = 1'b0;
            if (k == 7) req_f = 1'b0;
        end

        // ---- both requesters held: strict alternation I,F,I,F,I,F ----
        do_reset();
        exp_seq[0] = 32'h100; exp_seq[1] = 32'h200; exp_seq[2] = 32'h104;
        exp_seq[3] = 32'h204; exp_seq[4] = 32'h108; exp_seq[5] = 32'h208;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
        req_f = 1'b1; we_f = 1'b0; addr_f = 32'h200;
        ni = 1; nf = 1; seen = 0; prev = 1'b0;
        for (int k = 0; k < 60 && (req_i || req_f); k++) begin
            @(negedge clk);
            ai = ack_i; af = ack_f;
            if (mem_req && !prev) begin
                if (seen < 6) check($sformatf("t3_seq%0d", seen), mem_addr, exp_seq[seen]);
                seen++;
            end
            prev = mem_req;
            step();
            if (ai) begin
                if (ni < 3) begin addr_i = 32'h100 + 32'(4 * ni); ni++; end
                else req_i = 1'b0;
            end
            if (af) begin
                if (nf < 3) begin addr_f = 32'h200 + 32'(4 * nf); nf++; end
                else req_f = 1'b0;
            end
        end
        check("t3_count", seen, 6);
        drain();

        // ---- grant delayed 3 cycles; payload change after sampling ignored ----
        gnt_wait = 3;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; wdata_i = 32'h1234_5678;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("t4_ack_i", ack_i, k == 6);
            if (k >= 1 && k <= 4) begin
                check("t4_mem_req", mem_req, 1);
                check("t4_mem_addr", mem_addr, 32'h80);
                check("t4_mem_wdata", mem_wdata, 32'h1234_5678);
            end
            if (k == 5) check("t4_mem_req_drop", mem_req, 0);
            step();
            if (k == 1) addr_i = 32'hFFC;
            if (k == 6) req_i = 1'b0;
        end
        gnt_wait = 0;

        // ---- timeout: rvalid never comes ----
        do_reset();
        never_rv = 1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h44;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            check("t5_ack_i", ack_i, k == 17);
            check("t5_bus_err", bus_err, k >= 17);
            if (k == 17) check("t5_rdata", rdata, 0);
            step();
            if (k == 17) req_i = 1'b0;
        end
        never_rv = 0;
        rd_val = 32'hCAFE_0001;
        req_i = 1'b1; addr_i = 32'h48;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("t5b_ack_i", ack_i, k == 3);
            check("t5b_bus_err", bus_err, 1);
            if (k == 3) check("t5b_rdata", rdata, 32'hCAFE_0001);
            step();
            if (k == 3) req_i = 1'b0;
        end

        // ---- reset during RESP, stale rvalid afterwards ----
        rsp_wait = 100;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h50;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; req_i = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6_ack_i", ack_i, 0);
            check("t6_ack_f", ack_f, 0);
            check("t6_rdata", rdata, 0);
            check("t6_mem_req", mem_req, 0);
            check("t6_mem_addr", mem_addr, 0);
            check("t6_bus_err", bus_err, 0);
            step();
        end
        rsp_wait = 0;
        req_i = 1'b1; addr_i = 32'h60;
        req_f = 1'b1; addr_f = 32'h70;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check("t6_conf_ack_i", ack_i, k == 3);
            check("t6_conf_ack_f", ack_f, k == 7);
            if (k == 1) check("t6_conf_addr", mem_addr, 32'h60);
            step();
            if (k == 3) req_i = 1'b0;
            if (k == 7) req_f = 1'b0;
        end

        // ---- randomized soak ----
        do_reset();
        rnd_mem = 1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            ai = ack_i; af = ack_f;
            step();
            rst = ($urandom_range(0, 399) != 0);
            if (ai || !req_i) begin
                req_i   = ($urandom_range(0, 2) != 0);
                we_i    = $urandom_range(0, 1) == 1;
                addr_i  = AW'($urandom) & 32'h3FC;
                wdata_i = DW'($urandom);
            end else if (!(m_busy && !m_win) && $urandom_range(0, 7) == 0) begin
                addr_i  = AW'($urandom) & 32'h3FC;
                wdata_i = DW'($urandom);
            end
            if (af || !req_f) begin
                req_f   = ($urandom_range(0, 2) != 0);
                we_f    = $urandom_range(0, 1) == 1;
                addr_f  = AW'($urandom) & 32'h3FC;
                wdata_f = DW'($urandom);
            end else if (!(m_busy && m_win) && $urandom_range(0, 7) == 0) begin
                addr_f  = AW'($urandom) & 32'h3FC;
                wdata_f = DW'($urandom);
            end
        end
        rst = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single data-memory port between the integer MEM stage and the FP MEM stage (FLW/FSW path).
- Sequences each access through a request/grant/response handshake and generates per-requester stalls.
- Sits between both MEM stages and the data memory. Replaces the ad-hoc sharing inside the MEM stage and provides the source for mem_stall.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in REQ+RESP before bus error (must be >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (asserted when 0, sampled on rising clk)
req_i  in  1  integer-side access request, held until ack_i
we_i  in  1  integer-side write (1) / read (0)
addr_i  in  ADDR_W  integer-side address
wdata_i  in  DATA_W  integer-side store data
req_f  in  1  FP-side access request, held until ack_f
we_f  in  1  FP-side write/read
addr_f  in  ADDR_W  FP-side address
wdata_f  in  DATA_W  FP-side store data
ack_i  out  1  one-cycle completion pulse, integer side
ack_f  out  1  one-cycle completion pulse, FP side
rdata  out  DATA_W  load data, valid in the ack cycle
stall_i  out  1  req_i & ~ack_i
stall_f  out  1  req_f & ~ack_f
mem_req  out  1  memory command valid
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepts command this cycle
mem_rvalid  in  1  memory completion (reads and writes)
mem_rdata  in  DATA_W  memory read data
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including mem_req, ack_i/ack_f, rdata, bus_err and the timeout counter.
  - rr_last = FP, so the integer side wins the first conflict.
  - Reset mid-transaction abandons it; a later mem_rvalid is ignored while in IDLE.
- FSM: IDLE -> REQ -> RESP -> ACK -> IDLE.
- IDLE:
  - If only one req is high, that side wins.
  - If both are high, the side not equal to rr_last wins.
  - Winner's we/addr/wdata are latched and the winner ID is recorded. Next state is REQ.
  - The loser stays stalled.
- REQ:
  - mem_req=1; mem_* driven from latched registers, stable until accepted.
  - On mem_gnt, the next state is RESP and mem_req drops.
  - mem_rvalid in REQ is ignored; memory never completes in its grant cycle.
- RESP: on mem_rvalid, capture mem_rdata (writes capture too; requester ignores it). Next state is ACK.
- ACK:
  - Winner's ack is high for exactly one cycle with rdata valid.
  - rr_last <= winner. Next state is IDLE.
  - The requester drops or changes req at the next edge. IDLE never sees a stale req because ack precedes it.
- Minimum latency: req seen in IDLE at cycle 0, mem_req at 1 (gnt same cycle), rvalid at 2, ack at 3.
- Timeout:
  - The counter is cleared on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT-1 without completion, go to ACK with rdata=0, set bus_err, and drop mem_req.
  - bus_err is sticky until reset.
- Back-to-back: with both requesters continuously requesting, grants alternate I,F,I,F.
- Single requester: it is granted every transaction, with no bubble beyond the ACK->IDLE cycle.
- Request payload changes while not yet granted are allowed. Payload is sampled only in IDLE.
- stall_x is combinational from req_x and ack_x. No other combinational paths from mem_* inputs to outputs.

Decomposition:
- Shared core package holds:
  - the state encoding (IDLE/REQ/RESP/ACK, 2 bits);
  - requester ID constants (REQ_INT=0, REQ_FP=1);
  - the default ADDR_W/DATA_W.
- No sub-module required. Optionally factor out the 2-way round-robin picker as rr_pick2 (combinational, with rr_last input).

Test Plan:
- Integer-only load, addr=0x40: gnt immediately, rvalid 1 cycle later with 0xDEADBEEF -> ack_i at cycle 3, rdata=0xDEADBEEF, stall_i high cycles 0-2, ack_f never.
- Simultaneous int store (0x10, 0x1) and FP load (0x20) after reset -> integer granted first (mem_addr=0x10, mem_we=1), then FP (mem_addr=0x20). Ack order I then F; stall_f high until its ack.
- Both requesters held for 6 transactions -> mem_addr sequence alternates int/FP addresses exactly I,F,I,F,I,F.
- mem_gnt delayed 3 cycles -> mem_req/mem_addr/mem_wdata stable across the wait; ack asserted 3 cycles later than the minimum.
- mem_rvalid never asserted, TIMEOUT=16 -> ack of winner after the counter expires, rdata=0, bus_err=1 and sticky, next request still serviced normally.
- rst=0 asserted in RESP, stale mem_rvalid the next cycle -> no ack, all outputs 0, the next conflict is again won by integer.
